// File: rtl/sliding_window_pattern_detector.sv
// Serial pattern detector over a sliding W-bit window with runtime pattern/mask and optional
// overlap suppression. Define MATCH_COUNT_EN to add the saturating match_cnt output.
module sliding_window_pattern_detector #(
  parameter int W       = 8,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  output logic             out,
  output logic             armed
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FW = $clog2(W);
  localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [W-2:0]    hist_q, hist_d;
  logic [W-1:0]    pattern_q, pattern_d;
  logic [W-1:0]    mask_q, mask_d;
  logic [W-1:0]    cand;
  logic            hit;

  // Bit 0 of the candidate window is the bit being presented this cycle.
  assign cand  = {hist_q, in};
  assign hit   = ((cand ^ pattern_q) & mask_q) == '0;
  assign armed = (state_q == S_RUN);
  assign out   = en & armed & ~cfg_we & hit;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hist_d    = hist_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    if (cfg_we) begin
      // Reconfiguring discards the window contents logically; hist is reused once refilled.
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (en) begin
      hist_d = cand[W-2:0];
      case (state_q)
        S_FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST - 1'b1) state_d = S_RUN;
        end
        S_RUN: begin
          if (out && (OVERLAP == 0)) begin
            fill_d  = '0;
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      fill_q    <= '0;
      hist_q    <= '0;
      pattern_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      hist_q    <= hist_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
    end
  end

`ifdef MATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cfg_we) begin
      match_cnt <= '0;
    end else if (out && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_sliding_window_pattern_detector.sv
// Bench for sliding_window_pattern_detector: two instances (overlap and non-overlap) share one
// input stream; a window-history reference model predicts out/armed/match_cnt every cycle.
module tb_sliding_window_pattern_detector;

  localparam int W     = 4;
  localparam int CNT_W = 2;
  localparam int EW    = 4 + 2 * CNT_W;

  logic             clk;
  logic             rst_n;
  logic             in;
  logic             en;
  logic             cfg_we;
  logic [W-1:0]     cfg_pattern;
  logic [W-1:0]     cfg_mask;
  logic             out_ov, armed_ov, out_no, armed_no;
  logic [CNT_W-1:0] cnt_ov, cnt_no;

  sliding_window_pattern_detector #(.W(W), .OVERLAP(1), .CNT_W(CNT_W)) u_ov (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .out(out_ov), .armed(armed_ov)
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt_ov)
`endif
  );

  sliding_window_pattern_detector #(.W(W), .OVERLAP(0), .CNT_W(CNT_W)) u_no (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .out(out_no), .armed(armed_no)
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt_no)
`endif
  );

`ifndef MATCH_COUNT_EN
  assign cnt_ov = '0;
  assign cnt_no = '0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: accepted-bit history plus bits accepted since each instance last restarted
  bit         win_q[$];
  int         since[2];
  int         mcnt[2];
  logic [W-1:0] m_pat;
  logic [W-1:0] m_msk;

  function automatic bit window_matches(bit b);
    bit v;
    for (int i = 0; i < W; i++) begin
      v = (i == 0) ? b : win_q[win_q.size() - i];
      if (m_msk[i] && (v != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    win_q.delete();
    since[0] = 0; since[1] = 0;
    mcnt[0]  = 0; mcnt[1]  = 0;
    m_pat = '0;
    m_msk = '1;
  endtask

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of stimulus, predict this cycle's outputs, then advance the model
  task automatic drive(input bit b, input bit e, input bit we, input logic [W-1:0] p,
                       input logic [W-1:0] k, input bit r);
    bit arm[2];
    bit o[2];
    bit hit;
    in = b; en = e; cfg_we = we; cfg_pattern = p; cfg_mask = k; rst_n = r;
    hit = 1'b0;
    if (since[0] >= W - 1) hit = window_matches(b);
    for (int m = 0; m < 2; m++) begin
      arm[m] = (since[m] >= W - 1);
      o[m]   = e && !we && arm[m] && hit;
    end
    exp_q.push_back({o[0], arm[0], o[1], arm[1], CNT_W'(mcnt[0]), CNT_W'(mcnt[1])});
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
    end else if (we) begin
      m_pat = p; m_msk = k;
      since[0] = 0; since[1] = 0;
      mcnt[0]  = 0; mcnt[1]  = 0;
    end else if (e) begin
      win_q.push_back(b);
      if (win_q.size() > W) void'(win_q.pop_front());
      for (int m = 0; m < 2; m++) begin
        if (o[m] && mcnt[m] < (1 << CNT_W) - 1) mcnt[m]++;
        if (o[m] && m == 1) since[m] = 0;
        else if (since[m] < 1000) since[m]++;
      end
    end
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic load(input logic [W-1:0] p, input logic [W-1:0] k);
    drive(1'b0, 1'b0, 1'b1, p, k, 1'b1);
  endtask

  // monitor: outputs are Mealy, so sample mid-cycle before the consuming edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1("out_overlap",    int'(out_ov),   int'(e[EW-1]));
      check1("armed_overlap",  int'(armed_ov), int'(e[EW-2]));
      check1("out_nonoverlap", int'(out_no),   int'(e[EW-3]));
      check1("armed_nonoverlap", int'(armed_no), int'(e[EW-4]));
`ifdef MATCH_COUNT_EN
      check1("cnt_overlap",    int'(cnt_ov), int'(e[2*CNT_W-1:CNT_W]));
      check1("cnt_nonoverlap", int'(cnt_no), int'(e[CNT_W-1:0]));
`endif
    end
  end

  initial begin
    logic [W-1:0] rp, rk;
    rst_n = 1'b0; in = 1'b0; en = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_mask = '0;
    @(posedge clk);
    #1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // example stream 1,0,1,1,0,1,1 against 1011
    load(4'b1011, 4'b1111);
    feed(16'b1011011, 7);

    // six ones against 1111
    load(4'b1111, 4'b1111);
    feed(16'b111111, 6);

    // enable gap with toggling input mid-stream
    load(4'b1011, 4'b1111);
    feed(16'b10, 2);
    for (int i = 0; i < 5; i++) drive(i[0], 1'b0, 1'b0, '0, '0, 1'b1);
    feed(16'b11011, 5);

    // reconfigure while running: two newest bits must be 00
    load(4'b0000, 4'b0011);
    for (int i = 0; i < 12; i++) drive(($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);

    // mask all don't-care: every armed bit matches, counter saturates
    load(4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) drive(1'($urandom), 1'b1, 1'b0, '0, '0, 1'b1);

    // reset mid-stream restores pattern 0 / mask all ones
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    feed(16'b000000, 6);
    feed(16'b0100, 4);

    // cfg_we colliding with en: input bit not consumed
    feed(16'b1111, 4);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 4'b1110, 1'b1);
    feed(16'b0110110, 7);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rp = W'($urandom);
      rk = W'($urandom) & W'($urandom);
      drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
            rp, rk, $urandom_range(0, 150) != 0);
    end

    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check1("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
